wb_commit: RTL and testbench
============================

// Module: wb_commit
// PURPOSE
//  Writer side of the 32x32 integer register file: merges single-cycle ALU results and
//  long-latency LSU/MUL results into the file's single write port (rd/reg_wen/data_in).
//  Buffers long-latency results in a small FIFO and keeps a per-register pending scoreboard
//  so decode can detect RAW/WAW hazards on registers awaiting a long-latency write.
// PARAMETERS
//  XLEN   32  data width
//  DEPTH  2   long-latency result FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1     core clock
//  rst_n        in   1     asynchronous active-low reset
//  alu_valid    in   1     ALU result present this cycle (no ready; always accepted)
//  alu_rd       in   5     ALU destination
//  alu_data     in   XLEN  ALU result
//  lsu_valid    in   1     long-latency result offered
//  lsu_ready    out  1     = !fifo_full; transfer when lsu_valid & lsu_ready
//  lsu_rd       in   5     long-latency destination
//  lsu_data     in   XLEN  long-latency result
//  issue_valid  in   1     long-latency op issued this cycle; marks issue_rd pending
//  issue_rd     in   5     destination of the issued op
//  rs1,rs2      in   5     decode source addresses
//  rs1_busy     out  1     scoreboard[rs1] (comb); same for rs2_busy
//  rd_busy      out  1     scoreboard[issue_rd] (comb), decode stalls issue on WAW
//  wb_stall     out  1     FIFO full; pipeline must insert an ALU bubble
//  rf_rd        out  5     to register file rd
//  rf_wen       out  1     to register file reg_wen
//  rf_wdata     out  XLEN  to register file data_in
// BEHAVIOUR
//  - Reset (async): rf_wen=0, rf_rd=0, rf_wdata=0, scoreboard all 0, FIFO empty (count=0).
//  - Write port registered: source selected in cycle N drives rf_* in cycle N+1; RF commits at edge N+2.
//  - Priority: alu_valid wins the port. Otherwise FIFO head pops if non-empty.
//  - LSU results always pass through FIFO: accept N, earliest rf_wen N+2 (pop N+1).
//  - Push and pop in same cycle allowed; count unchanged; full FIFO accepts no push even if popping.
//  - rd==0 from either source: entry still consumed/popped, rf_wen=0 for that slot.
//  - Scoreboard: set bit issue_rd on issue_valid (bit 0 never set); clear bit rf_rd when a
//    FIFO entry is popped. Set and clear of same index in one cycle: set wins.
//  - ALU write to a pending rd is a decode contract violation; simulation assertion fires.
//  - wb_stall = (count==DEPTH); ALU writes starve the FIFO only while software keeps ALU busy.
//  - Reset mid-operation: FIFO contents and pending bits discarded; no rf_wen after reset.
// CONFIGURATION
//  WB_FWD_EN defined: adds rs1_fwd_hit/rs2_fwd_hit (1) and rs1_fwd_data/rs2_fwd_data (XLEN);
//   hit = rf_wen & rf_rd==rsN & rsN!=0, data = rf_wdata, covering the write not yet in RF.
//  WB_FWD_EN undefined: ports absent; decode stalls one extra cycle on a same-cycle match.
// STRUCTURE
//  - Shared constants include: `zero_word, REG_ADDR_W=5, REG_NUM=32.
//  - Sub-module wb_fifo (DEPTH x {5-bit rd, XLEN data}, count, full/empty); scoreboard,
//    arbitration and output register live in wb_commit.
// TESTING
//  - Reset: rst_n low mid-stream -> rf_wen=0, rs*_busy=0, lsu_ready=1 immediately.
//  - alu_valid, rd=5, data=0x1234 at N -> rf_wen=1, rf_rd=5, rf_wdata=0x1234 at N+1 only.
//  - issue rd=7; lsu rd=7 data=0xDEAD accepted at N -> rs1_busy(rs1=7)=1 until pop; rf_wen at N+2; busy 0 at N+2.
//  - ALU every cycle while 2 LSU results arrive -> lsu_ready=0, wb_stall=1; ALU bubble drains in order.
//  - Pop and issue_valid same rd same cycle -> bit stays set; rd=0 LSU result -> pop, rf_wen=0.
//  - WB_FWD_EN: rf_wen rd=3 data=0x55 with rs2=3 -> rs2_fwd_hit=1, rs2_fwd_data=0x55; rs2=0 -> hit=0.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_pkg
//  Shared constants, the write-port source select type and a small one-hot
//  helper used by the register-file write-back block (wb_commit) and its
//  long-latency result FIFO (wb_fifo).
//  Contents:
//   REG_ADDR_W  register address width (5)
//   REG_NUM     number of integer registers (32)
//   XLEN_DEF    default data width (32)
//   zero_word   all-zero data word
//   wb_src_e    which source owns the register-file write port this cycle
//   reg_onehot  register index -> one-hot register mask
// -----------------------------------------------------------------------------
package wb_commit_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_NUM    = 32;
   localparam int XLEN_DEF   = 32;

   localparam logic [XLEN_DEF-1:0] zero_word = '0;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_FIFO = 2'd2
   } wb_src_e;

   function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
      reg_onehot      = '0;
      reg_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//  Small FIFO holding long-latency results {rd, data} until the register-file
//  write port is free. The head entry is read combinationally so that the
//  cycle which pops it can also load it into the write-port register.
//  Ports:
//   clk      in   core clock
//   rst_n    in   asynchronous active-low reset (empties the FIFO)
//   push_i   in   write wdata_i (ignored while full)
//   pop_i    in   drop the head entry (ignored while empty)
//   wdata_i  in   W-bit entry to write
//   rdata_o  out  W-bit head entry
//   count_o  out  number of valid entries
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when the same cycle pops.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit
//  Writer side of the 32x32 integer register file. Merges single-cycle ALU
//  results and long-latency (LSU/MUL) results onto the file's single write
//  port. Long-latency results are buffered in wb_fifo; a per-register pending
//  scoreboard lets decode detect RAW/WAW hazards on outstanding writes.
//  Optional feature macro: WB_FWD_EN (adds rs1/rs2 forwarding of the write
//  currently on the port, i.e. the one not yet visible in the register file).
//  Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid_i/alu_rd_i/alu_data_i   ALU result, always accepted
//   lsu_valid_i/lsu_rd_i/lsu_data_i   long-latency result, handshake with lsu_ready_o
//   lsu_ready_o                   FIFO not full
//   issue_valid_i/issue_rd_i      long-latency issue, marks issue_rd_i pending
//   rs1_i, rs2_i                  decode source addresses
//   rs1_busy_o, rs2_busy_o        pending bit of rs1_i / rs2_i
//   rd_busy_o                     pending bit of issue_rd_i (WAW)
//   wb_stall_o                    FIFO full, pipeline must insert an ALU bubble
//   rf_rd_o/rf_wen_o/rf_wdata_o   registered register-file write port
//   rs1_fwd_hit_o/rs1_fwd_data_o, rs2_fwd_hit_o/rs2_fwd_data_o  (WB_FWD_EN only)
// -----------------------------------------------------------------------------
module wb_commit
   import wb_commit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [REG_ADDR_W-1:0] alu_rd_i,
   input  logic [XLEN-1:0]       alu_data_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [REG_ADDR_W-1:0] lsu_rd_i,
   input  logic [XLEN-1:0]       lsu_data_i,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o,
   output logic                  rd_busy_o,
   output logic                  wb_stall_o,
   output logic [REG_ADDR_W-1:0] rf_rd_o,
   output logic                  rf_wen_o,
   output logic [XLEN-1:0]       rf_wdata_o
`ifdef WB_FWD_EN
   ,
   output logic                  rs1_fwd_hit_o,
   output logic [XLEN-1:0]       rs1_fwd_data_o,
   output logic                  rs2_fwd_hit_o,
   output logic [XLEN-1:0]       rs2_fwd_data_o
`endif
);

   localparam int EW = REG_ADDR_W + XLEN;
   localparam int CW = $clog2(DEPTH + 1);

   logic [EW-1:0]         fifo_head;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [XLEN-1:0]       head_data;
   wb_src_e               src;

   logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

   logic [REG_NUM-1:0]    sb_q, sb_d, sb_set, sb_clr;

   assign head_rd   = fifo_head[EW-1 -: REG_ADDR_W];
   assign head_data = fifo_head[XLEN-1:0];

   assign push = lsu_valid_i & ~fifo_full;
   assign pop  = (src == SRC_FIFO);

   wb_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({lsu_rd_i, lsu_data_i}),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ALU owns the port whenever it has a result; the FIFO drains in gaps.
   always_comb begin
      src = SRC_NONE;
      if (alu_valid_i) begin
         src = SRC_ALU;
      end else if (!fifo_empty) begin
         src = SRC_FIFO;
      end
   end

   // rd==0 still consumes its slot but never raises the write enable.
   always_comb begin
      rf_wen_d   = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      unique case (src)
         SRC_ALU: begin
            rf_wen_d   = (alu_rd_i != '0);
            rf_rd_d    = alu_rd_i;
            rf_wdata_d = alu_data_i;
         end
         SRC_FIFO: begin
            rf_wen_d   = (head_rd != '0);
            rf_rd_d    = head_rd;
            rf_wdata_d = head_data;
         end
         default: begin
            rf_wen_d = 1'b0;
         end
      endcase
   end

   // Pending bits clear as the entry leaves the FIFO; a same-cycle issue to
   // the same register re-arms the bit (set has priority). r0 is never pending.
   assign sb_set = issue_valid_i ? reg_onehot(issue_rd_i) : '0;
   assign sb_clr = pop ? reg_onehot(head_rd) : '0;

   generate
      for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_sb
         assign sb_d[gi] = (gi != 0) && (sb_set[gi] || (sb_q[gi] && !sb_clr[gi]));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen_q   <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= XLEN'(zero_word);
         sb_q       <= '0;
      end else begin
         rf_wen_q   <= rf_wen_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         sb_q       <= sb_d;
      end
   end

   assign rf_wen_o    = rf_wen_q;
   assign rf_rd_o     = rf_rd_q;
   assign rf_wdata_o  = rf_wdata_q;
   assign lsu_ready_o = ~fifo_full;
   assign wb_stall_o  = (fifo_count == CW'(DEPTH));
   assign rs1_busy_o  = sb_q[rs1_i];
   assign rs2_busy_o  = sb_q[rs2_i];
   assign rd_busy_o   = sb_q[issue_rd_i];

`ifdef WB_FWD_EN
   // The write on the port now only reaches the register file at the next edge.
   assign rs1_fwd_hit_o  = rf_wen_q && (rf_rd_q == rs1_i) && (rs1_i != '0);
   assign rs2_fwd_hit_o  = rf_wen_q && (rf_rd_q == rs2_i) && (rs2_i != '0);
   assign rs1_fwd_data_o = rf_wdata_q;
   assign rs2_fwd_data_o = rf_wdata_q;
`endif

`ifndef SYNTHESIS
   // Decode must never let an ALU op target a register awaiting a long-latency write.
   a_alu_to_pending: assert property (
      @(posedge clk) disable iff (!rst_n)
      (alu_valid_i && (alu_rd_i != '0)) |-> !sb_q[alu_rd_i]
   );
`endif

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk;
   logic            rst_n;
   logic            alu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic            lsu_valid_i;
   logic            lsu_ready_o;
   logic [4:0]      lsu_rd_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            issue_valid_i;
   logic [4:0]      issue_rd_i;
   logic [4:0]      rs1_i, rs2_i;
   logic            rs1_busy_o, rs2_busy_o, rd_busy_o, wb_stall_o;
   logic [4:0]      rf_rd_o;
   logic            rf_wen_o;
   logic [XLEN-1:0] rf_wdata_o;
`ifdef WB_FWD_EN
   logic            rs1_fwd_hit_o, rs2_fwd_hit_o;
   logic [XLEN-1:0] rs1_fwd_data_o, rs2_fwd_data_o;
`endif

   wb_commit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid_i   (alu_valid_i),
      .alu_rd_i      (alu_rd_i),
      .alu_data_i    (alu_data_i),
      .lsu_valid_i   (lsu_valid_i),
      .lsu_ready_o   (lsu_ready_o),
      .lsu_rd_i      (lsu_rd_i),
      .lsu_data_i    (lsu_data_i),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .rs1_busy_o    (rs1_busy_o),
      .rs2_busy_o    (rs2_busy_o),
      .rd_busy_o     (rd_busy_o),
      .wb_stall_o    (wb_stall_o),
      .rf_rd_o       (rf_rd_o),
      .rf_wen_o      (rf_wen_o),
      .rf_wdata_o    (rf_wdata_o)
`ifdef WB_FWD_EN
      ,
      .rs1_fwd_hit_o  (rs1_fwd_hit_o),
      .rs1_fwd_data_o (rs1_fwd_data_o),
      .rs2_fwd_hit_o  (rs2_fwd_hit_o),
      .rs2_fwd_data_o (rs2_fwd_data_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
   typedef struct { int due; logic [4:0] rd; logic [31:0] data; } exp_t;

   bit   pend [32];
   ent_t mq [$];     // long-latency results waiting for the port
   exp_t exp_q [$];  // register-file writes the DUT owes, with the cycle they must appear

   task automatic model_reset();
      foreach (pend[i]) pend[i] = 1'b0;
      mq.delete();
      exp_q.delete();
   endtask

   // One clock cycle of stimulus, comb-output checks, and model update.
   task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
      int   c;
      bit   full;
      ent_t e;
      @(posedge clk);
      #1;
      alu_valid_i = av;  alu_rd_i = ard;  alu_data_i = ad;
      lsu_valid_i = lv;  lsu_rd_i = lrd;  lsu_data_i = ld;
      issue_valid_i = iv; issue_rd_i = ird;
      rs1_i = r1; rs2_i = r2;
`ifdef WB_FWD_EN
      #1;
      begin
         bit          h1, h2;
         logic [31:0] d;
         h1 = 1'b0; h2 = 1'b0; d = '0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            d  = exp_q[0].data;
            h1 = (exp_q[0].rd == r1) && (r1 != 0);
            h2 = (exp_q[0].rd == r2) && (r2 != 0);
         end
         chk("rs1_fwd_hit", rs1_fwd_hit_o, h1);
         chk("rs2_fwd_hit", rs2_fwd_hit_o, h2);
         if (h1) chk("rs1_fwd_data", rs1_fwd_data_o, d);
         if (h2) chk("rs2_fwd_data", rs2_fwd_data_o, d);
      end
`endif
      @(negedge clk);
      c    = cyc;
      full = (mq.size() == DEPTH);
      chk("lsu_ready", lsu_ready_o, !full);
      chk("wb_stall", wb_stall_o, full);
      chk("rs1_busy", rs1_busy_o, pend[r1]);
      chk("rs2_busy", rs2_busy_o, pend[r2]);
      chk("rd_busy", rd_busy_o, pend[ird]);
      // The port goes to the ALU if it has a result, else to the oldest buffered result.
      if (av) begin
         if (ard != 0) exp_q.push_back('{due: c + 1, rd: ard, data: ad});
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         if (e.rd != 0) exp_q.push_back('{due: c + 1, rd: e.rd, data: e.data});
         pend[e.rd] = 1'b0;
      end
      if (lv && !full) mq.push_back('{rd: lrd, data: ld});
      if (iv && ird != 0) pend[ird] = 1'b1;
   endtask

   task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
   endtask

   function automatic logic [4:0] pick_free();
      logic [4:0] r;
      for (int t = 0; t < 100; t++) begin
         r = 5'($urandom_range(0, 31));
         if (!pend[r]) return r;
      end
      return 5'd0;
   endfunction

   // ---------------- monitor: pops expected writes as the port presents them ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rf_wen", rf_wen_o, 1'b1);
            chk("rf_rd", rf_rd_o, e.rd);
            chk("rf_wdata", rf_wdata_o, e.data);
            $display("cyc %0d write rd=%0d data=0x%08h", cyc, rf_rd_o, rf_wdata_o);
         end else begin
            chk("rf_wen_idle", rf_wen_o, 1'b0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit         av, lv, iv;
      logic [4:0] ard, lrd, ird, r1, r2;
      rst_n = 1'b0;
      alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
      lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
      issue_valid_i = 0; issue_rd_i = 0; rs1_i = 0; rs2_i = 0;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rf_wen", rf_wen_o, 1'b0);
      chk("reset_rf_rd", rf_rd_o, 5'd0);
      chk("reset_rf_wdata", rf_wdata_o, 32'd0);
      chk("reset_lsu_ready", lsu_ready_o, 1'b1);
      chk("reset_wb_stall", wb_stall_o, 1'b0);
      rst_n = 1'b1;

      // ALU write appears exactly one cycle later, once.
      cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
      idle(2, 5, 0);

      // Issue rd=7, its LSU result arrives next cycle; watch rs1_busy clear on pop.
      cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      cycle(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 7, 0);
      idle(3, 7, 0);

      // ALU busy every cycle while LSU results pile up: FIFO fills and stalls.
      cycle(0, 0, 0, 0, 0, 0, 1, 10, 10, 11);
      cycle(0, 0, 0, 0, 0, 0, 1, 11, 10, 11);
      cycle(1, 20, 32'hA0, 1, 10, 32'h1010, 0, 0, 10, 11);
      cycle(1, 21, 32'hA1, 1, 11, 32'h1111, 0, 0, 10, 11);
      cycle(1, 22, 32'hA2, 1, 12, 32'h1212, 0, 0, 10, 11);
      cycle(1, 23, 32'hA3, 0, 0, 0, 0, 0, 10, 11);
      idle(4, 10, 11);

      // Pop and re-issue of the same register in one cycle: the bit stays set.
      cycle(0, 0, 0, 0, 0, 0, 1, 13, 13, 0);
      cycle(0, 0, 0, 1, 13, 32'h1313, 0, 0, 13, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 13, 13, 0);
      idle(2, 13, 0);
      cycle(0, 0, 0, 1, 13, 32'h2313, 0, 0, 13, 0);
      idle(3, 13, 0);

      // rd=0 long-latency result: popped with no write.
      cycle(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0);
      idle(3, 0, 0);

      // Forwarding-style case: write rd=3 then look at rs2=3 and rs2=0.
      cycle(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      cycle(1, 3, 32'h56, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

      // Randomized traffic, heavy ALU first (exercises stalls), then light.
      for (int i = 0; i < 500; i++) begin
         av  = ($urandom_range(0, 99) < ((i < 250) ? 75 : 35));
         ard = pick_free();
         lv  = ($urandom_range(0, 99) < 50);
         lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         iv  = ($urandom_range(0, 99) < 30);
         ird = 5'($urandom_range(0, 31));
         r1  = 5'($urandom_range(0, 31));
         r2  = ($urandom_range(0, 1) == 0) ? ard : 5'($urandom_range(0, 31));
         cycle(av, ard, $urandom, lv, lrd, $urandom, iv, ird, r1, r2);
      end
      idle(4, 0, 0);

      // Reset mid-stream with a buffered result and pending bits outstanding.
      cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      cycle(1, 4, 32'h44, 1, 9, 32'h9999, 1, 14, 9, 14);
      cycle(1, 6, 32'h66, 1, 14, 32'hEEEE, 0, 0, 9, 14);
      @(posedge clk);
      #1;
      alu_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0;
      rs1_i = 9; rs2_i = 14; issue_rd_i = 9;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_rf_wen", rf_wen_o, 1'b0);
      chk("midreset_rs1_busy", rs1_busy_o, 1'b0);
      chk("midreset_rs2_busy", rs2_busy_o, 1'b0);
      chk("midreset_rd_busy", rd_busy_o, 1'b0);
      chk("midreset_lsu_ready", lsu_ready_o, 1'b1);
      chk("midreset_wb_stall", wb_stall_o, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      idle(4, 9, 14);

      for (int i = 0; i < 150; i++) begin
         av  = ($urandom_range(0, 99) < 50);
         ard = pick_free();
         lv  = ($urandom_range(0, 99) < 50);
         lrd = 5'($urandom_range(0, 31));
         iv  = ($urandom_range(0, 99) < 30);
         ird = 5'($urandom_range(1, 31));
         r1  = 5'($urandom_range(0, 31));
         r2  = 5'($urandom_range(0, 31));
         cycle(av, ard, $urandom, lv, lrd, $urandom, iv, ird, r1, r2);
      end
      idle(5, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
